syscall_io_unit: RTL and testbench
==================================

Name: syscall_io_unit

Overview:
- Responder side of the CPU syscall interface: takes the syscall strobe, the op code from $v0 and the argument from $a0, and services the request.
- Handles three ops: print-int pushes $a0 into an output FIFO drained by the board display/console; read-int stalls the CPU until the board input handshake delivers a word, then issues a write-back to $v0; exit halts the CPU.
- Sits beside the single-cycle datapath and drives its global stall and an auxiliary register-write port.

Parameters:
- SYS_OP_W, 4, width of the op code taken from $v0[SYS_OP_W-1:0]
- OP_PRINT_INT, 1, print-integer op code
- OP_READ_INT, 5, read-integer op code
- OP_EXIT, 10, exit op code
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- syscall  in  1  high while the current instruction is SYSCALL; held by the CPU while stall=1
- sys_op  in  SYS_OP_W  op code ($v0 low bits)
- sys_arg  in  32  argument ($a0)
- stall  out  1  freezes PC and register writes of the CPU (combinational)
- wb_en  out  1  auxiliary register-write enable
- wb_addr  out  5  write-back register, constant 2 ($v0)
- wb_data  out  32  write-back value
- in_valid  in  1  board input word available
- in_data  in  32  board input word
- in_ready  out  1  unit accepts in_data this cycle
- out_valid  out  1  output FIFO non-empty
- out_data  out  32  FIFO head word
- out_ready  in  1  consumer takes the head this cycle
- halted  out  1  exit executed
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- bad_op  out  1  sticky: unknown op seen

Behaviour:
- Reset values: state IDLE; stall=0, wb_en=0, wb_data=0, in_ready=0, out_valid=0, out_data=0 (head read of empty FIFO is 0), halted=0, fifo_count=0, bad_op=0.
- Reset at any point (mid-read, halted, FIFO full) discards FIFO contents and captured data.
- States: IDLE, WAIT_IN, WRITE_BACK, HALT.
- Handshakes: a transfer occurs on a rising edge with valid&ready both high. out_data is the FIFO head and must not change while out_valid=1 and out_ready=0.
- IDLE, syscall=0: stall=0, no action.
- IDLE, syscall=1, op=PRINT_INT: push when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle. On a push, stall=0 and the instruction retires this cycle. Otherwise stall=1, no push, retry each cycle (no duplicate pushes).
- IDLE, syscall=1, op=READ_INT: stall=1, next state WAIT_IN.
- WAIT_IN: stall=1, in_ready=1. On in_valid: capture in_data into wb_data, next state WRITE_BACK.
- WRITE_BACK: wb_en=1 for exactly one cycle, stall=0 (the CPU retires the syscall). Next state IDLE.
- IDLE, syscall=1, op=EXIT: stall=1, next state HALT.
- HALT: stall=1 and halted=1 until rst. The FIFO continues to drain.
- Unknown op with syscall=1: no action, stall=0, bad_op set (sticky until rst).
- FIFO: circular buffer with wrapping read/write pointers. A push and pop in the same cycle leave the count unchanged. Pop on empty is ignored. Draining is independent of state.
- wb_en is never high outside WRITE_BACK; wb_addr is always 2.
- Total syscall latency:
  - print-int: 0 extra cycles when FIFO not full.
  - read-int: 1 cycle in WAIT_IN after in_valid, plus 1 cycle WRITE_BACK (minimum 2 stall cycles).

Test Plan:
- Print-int ×3 (a0=7, 0xFFFFFFFF, 42), out_ready=0 → stall=0 on each, fifo_count 1→3; then out_ready=1 → out_data 7, 0xFFFFFFFF, 42 in order, count back to 0.
- Fill FIFO (4 pushes), 5th print-int with out_ready=0 → stall=1, count stays 4. Assert out_ready for one cycle → push accepted in that cycle, stall drops, count stays 4, order preserved.
- Read-int with in_valid low for 5 cycles then in_valid=1, in_data=0x1234 → stall=1 throughout WAIT_IN, in_ready=1. Next cycle: wb_en=1, wb_addr=2, wb_data=0x1234, stall=0. Following cycle: wb_en=0.
- Exit op 10 → stall=1 and halted=1 persist for 100 cycles; FIFO entries still drain; rst → halted=0, stall=0, count=0.
- rst asserted in WAIT_IN with 2 FIFO entries → next cycle state IDLE, stall=0, in_ready=0, fifo_count=0, out_valid=0.
- Op 3 → stall=0, bad_op=1, no FIFO or wb_en activity; bad_op remains 1 through a later print-int.

Source files
------------

// File: rtl/syscall_io_unit.sv
// Syscall responder: services print-int through an output FIFO, read-int through the board
// input handshake with a $v0 write-back, and exit by halting the CPU until reset.
module syscall_io_unit #(
   parameter int SYS_OP_W     = 4,
   parameter int OP_PRINT_INT = 1,
   parameter int OP_READ_INT  = 5,
   parameter int OP_EXIT      = 10,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            syscall,
   input  logic [SYS_OP_W-1:0]             sys_op,
   input  logic [31:0]                     sys_arg,
   output logic                            stall,
   output logic                            wb_en,
   output logic [4:0]                      wb_addr,
   output logic [31:0]                     wb_data,
   input  logic                            in_valid,
   input  logic [31:0]                     in_data,
   output logic                            in_ready,
   output logic                            out_valid,
   output logic [31:0]                     out_data,
   input  logic                            out_ready,
   output logic                            halted,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            bad_op
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_IN = 2'd1, WRITE_BACK = 2'd2, HALT = 2'd3} state_t;

   state_t            state_r, state_s;
   logic [31:0]       mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [31:0]       wb_data_r;
   logic              wb_en_r, halted_r, bad_op_r;
   logic              push_s, pop_s, stall_s, in_ready_s, capture_s, bad_set_s;

   assign pop_s = out_ready && (count_r != {CW{1'b0}});

   // Next-state and handshake decode
   always_comb begin
      state_s    = state_r;
      push_s     = 1'b0;
      stall_s    = 1'b0;
      in_ready_s = 1'b0;
      capture_s  = 1'b0;
      bad_set_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (syscall) begin
               case (sys_op)
                  SYS_OP_W'(OP_PRINT_INT): begin
                     if ((count_r < CW'(FIFO_DEPTH)) || pop_s) begin
                        push_s = 1'b1;
                     end else begin
                        stall_s = 1'b1;
                     end
                  end
                  SYS_OP_W'(OP_READ_INT): begin
                     stall_s = 1'b1;
                     state_s = WAIT_IN;
                  end
                  SYS_OP_W'(OP_EXIT): begin
                     stall_s = 1'b1;
                     state_s = HALT;
                  end
                  default: bad_set_s = 1'b1;
               endcase
            end else begin
               stall_s = 1'b0;
            end
         end
         WAIT_IN: begin
            stall_s    = 1'b1;
            in_ready_s = 1'b1;
            if (in_valid) begin
               capture_s = 1'b1;
               state_s   = WRITE_BACK;
            end else begin
               state_s = WAIT_IN;
            end
         end
         WRITE_BACK: state_s = IDLE;
         HALT:       stall_s = 1'b1;
         default:    state_s = IDLE;
      endcase
   end

   // Control state, write-back capture and sticky status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         wb_data_r <= 32'd0;
         wb_en_r   <= 1'b0;
         halted_r  <= 1'b0;
         bad_op_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         wb_en_r  <= (state_s == WRITE_BACK);
         halted_r <= (state_s == HALT);
         bad_op_r <= bad_op_r | bad_set_s;
         if (capture_s) begin
            wb_data_r <= in_data;
         end
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep the count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; stale words are masked by the empty check on the read side
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= sys_arg;
      end
   end

   assign stall      = stall_s;
   assign in_ready   = in_ready_s;
   assign wb_en      = wb_en_r;
   assign wb_addr    = 5'd2;
   assign wb_data    = wb_data_r;
   assign out_valid  = (count_r != {CW{1'b0}});
   assign out_data   = out_valid ? mem_r[rd_ptr_r] : 32'd0;
   assign halted     = halted_r;
   assign fifo_count = count_r;
   assign bad_op     = bad_op_r;
endmodule

// File: tb/tb_syscall_io_unit.sv
// Directed bench for syscall_io_unit: scoreboard queues for FIFO pops and write-backs,
// checked by a negedge monitor, plus direct status checks from the stimulus thread.
module tb_syscall_io_unit;
   logic        clk = 1'b0;
   logic        rst, syscall, in_valid, out_ready;
   logic [3:0]  sys_op;
   logic [31:0] sys_arg, in_data;
   logic        stall, wb_en, in_ready, out_valid, halted, bad_op;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, out_data;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] wb_q[$];

   syscall_io_unit dut (
      .clk(clk), .rst(rst), .syscall(syscall), .sys_op(sys_op), .sys_arg(sys_arg),
      .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .halted(halted), .fifo_count(fifo_count), .bad_op(bad_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // Monitor: FIFO pops and write-backs against the scoreboards
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", out_data, 32'hDEAD_BEEF);
         end else begin
            chk("pop_data", out_data, exp_q.pop_front());
         end
      end
      if (!rst && wb_en) begin
         if (wb_q.size() == 0) begin
            chk("unexpected_wb", wb_data, 32'hDEAD_BEEF);
         end else begin
            chk("wb_addr", {27'd0, wb_addr}, 32'd2);
            chk("wb_data", wb_data, wb_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; syscall = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      cyc(); cyc();
      exp_q.delete();
      wb_q.delete();
      rst = 1'b0;
   endtask

   task automatic print_ok(input logic [31:0] a, input logic [31:0] exp_count);
      cyc();
      syscall = 1'b1; sys_op = 4'd1; sys_arg = a;
      exp_q.push_back(a);
      neg();
      chk("print_stall", {31'd0, stall}, 32'd0);
      chk("print_count_before", {29'd0, fifo_count}, exp_count);
   endtask

   task automatic drain(input int n);
      cyc();
      syscall = 1'b0; out_ready = 1'b1;
      for (int i = 1; i < n; i++) cyc();
      cyc();
      out_ready = 1'b0;
      neg();
      chk("drain_count", {29'd0, fifo_count}, 32'd0);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      sys_op = 4'd0; sys_arg = 32'd0; in_data = 32'd0;
      do_reset();
      neg();
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_count", {29'd0, fifo_count}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_bad_op", {31'd0, bad_op}, 32'd0);
      chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_wb_addr", {27'd0, wb_addr}, 32'd2);

      // Three prints, then drain in order
      print_ok(32'd7, 32'd0);
      print_ok(32'hFFFF_FFFF, 32'd1);
      print_ok(32'd42, 32'd2);
      cyc();
      syscall = 1'b0;
      neg();
      chk("three_count", {29'd0, fifo_count}, 32'd3);
      chk("head_stable", out_data, 32'd7);
      drain(3);

      // Fill, stall on full, then push-with-pop
      for (int i = 0; i < 4; i++) print_ok(32'd100 + i, i);
      cyc();
      sys_arg = 32'd200;
      exp_q.push_back(32'd200);
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("full_stall", {31'd0, stall}, 32'd1);
         chk("full_count", {29'd0, fifo_count}, 32'd4);
         cyc();
      end
      out_ready = 1'b1;
      neg();
      chk("full_pushpop_stall", {31'd0, stall}, 32'd0);
      cyc();
      syscall = 1'b0; out_ready = 1'b0;
      neg();
      chk("full_after_count", {29'd0, fifo_count}, 32'd4);
      drain(4);

      // Read-int with delayed input
      cyc();
      syscall = 1'b1; sys_op = 4'd5;
      neg();
      chk("rd_idle_stall", {31'd0, stall}, 32'd1);
      chk("rd_idle_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         neg();
         chk("rd_wait_stall", {31'd0, stall}, 32'd1);
         chk("rd_wait_in_ready", {31'd0, in_ready}, 32'd1);
      end
      cyc();
      in_valid = 1'b1; in_data = 32'h1234;
      wb_q.push_back(32'h1234);
      neg();
      chk("rd_accept_stall", {31'd0, stall}, 32'd1);
      cyc();
      in_valid = 1'b0; in_data = 32'h5555;
      neg();
      chk("wb_en_high", {31'd0, wb_en}, 32'd1);
      chk("wb_stall", {31'd0, stall}, 32'd0);
      chk("wb_data_direct", wb_data, 32'h1234);
      cyc();
      syscall = 1'b0;
      neg();
      chk("wb_en_low", {31'd0, wb_en}, 32'd0);

      // Unknown op
      cyc();
      syscall = 1'b1; sys_op = 4'd3; sys_arg = 32'd99;
      neg();
      chk("bad_stall", {31'd0, stall}, 32'd0);
      cyc();
      syscall = 1'b0;
      neg();
      chk("bad_op_set", {31'd0, bad_op}, 32'd1);
      chk("bad_count", {29'd0, fifo_count}, 32'd0);
      chk("bad_wb_en", {31'd0, wb_en}, 32'd0);
      print_ok(32'd55, 32'd0);
      print_ok(32'd66, 32'd1);
      print_ok(32'd77, 32'd2);
      cyc();
      syscall = 1'b0;
      neg();
      chk("bad_sticky", {31'd0, bad_op}, 32'd1);
      chk("pre_exit_count", {29'd0, fifo_count}, 32'd3);

      // Exit: halt persists, FIFO still drains
      cyc();
      syscall = 1'b1; sys_op = 4'd10;
      neg();
      chk("exit_stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < 100; i++) begin
         cyc();
         out_ready = (i >= 10 && i < 13);
         neg();
         chk("halt_stall", {31'd0, stall}, 32'd1);
         chk("halt_halted", {31'd0, halted}, 32'd1);
      end
      chk("halt_drained", {29'd0, fifo_count}, 32'd0);
      out_ready = 1'b0;
      do_reset();
      neg();
      chk("post_halt_halted", {31'd0, halted}, 32'd0);
      chk("post_halt_stall", {31'd0, stall}, 32'd0);
      chk("post_halt_count", {29'd0, fifo_count}, 32'd0);

      // Reset in WAIT_IN with two FIFO entries
      print_ok(32'd8, 32'd0);
      print_ok(32'd9, 32'd1);
      cyc();
      sys_op = 4'd5;
      cyc();
      neg();
      chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
      chk("wait_count", {29'd0, fifo_count}, 32'd2);
      cyc();
      do_reset();
      neg();
      chk("rstw_stall", {31'd0, stall}, 32'd0);
      chk("rstw_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rstw_count", {29'd0, fifo_count}, 32'd0);
      chk("rstw_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstw_bad_op", {31'd0, bad_op}, 32'd0);
      cyc();
      neg();
      chk("exp_q_empty", exp_q.size(), 32'd0);
      chk("wb_q_empty", wb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
